// File: rtl/reset_prompt_ctrl.sv
// "RESET?" prompt controller: debounces confirm/dismiss buttons, blinks the prompt while
// game_over is newly raised, and issues a one-cycle game_reset or dismissed pulse.
module reset_prompt_ctrl #(
  parameter int unsigned DEB_TICKS     = 4,
  parameter int unsigned BLINK_TICKS   = 30,
  parameter int unsigned TIMEOUT_TICKS = 600
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic game_over,
  input  logic btn_yes,
  input  logic btn_no,
  output logic prompt_en,
  output logic game_reset,
  output logic dismissed,
  output logic busy
);

  localparam int unsigned DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  typedef enum logic [1:0] {StIdle, StPrompt, StPulse, StRelease} state_e;

  state_e state_q, state_d;

  // Bit 0 is the confirm button, bit 1 the dismiss button.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    db_q;
  logic [1:0]    press_q;
  logic [DW-1:0] deb_cnt_q [2];

  logic [BW-1:0] blink_q, blink_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          phase_q, phase_d;
  logic          go_q, armed_q, go_rise;

  assign btn_raw = {btn_no, btn_yes};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      press_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      if (tick) begin
        for (int i = 0; i < 2; i++) begin
          if (sync2_q[i] == db_q[i]) begin
            deb_cnt_q[i] <= '0;
          end else if (deb_cnt_q[i] == DW'(DEB_TICKS - 1)) begin
            deb_cnt_q[i] <= '0;
            db_q[i]      <= ~db_q[i];
            press_q[i]   <= ~db_q[i];  // only the 0->1 flip is an event
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  // armed_q stays low until game_over has been seen low since reset, so a level
  // already high when reset is released never counts as a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      go_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      go_q    <= game_over;
      armed_q <= armed_q | ~game_over;
    end
  end

  assign go_rise = game_over & ~go_q & armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      blink_q <= '0;
      tmo_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      tmo_q   <= tmo_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    tmo_d   = tmo_q;
    phase_d = phase_q;
    unique case (state_q)
      StIdle: begin
        if (go_rise) begin
          state_d = StPrompt;
          blink_d = '0;
          tmo_d   = '0;
          phase_d = 1'b1;
        end
      end
      StPrompt: begin
        if (tick) begin
          if (blink_q == BW'(BLINK_TICKS - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
          if (tmo_q == TW'(TIMEOUT_TICKS - 1)) tmo_d = '0;
          else                                 tmo_d = tmo_q + 1'b1;
        end
        if (press_q[1])                                   state_d = StRelease;
        else if (press_q[0])                              state_d = StPulse;
        else if (tick && tmo_q == TW'(TIMEOUT_TICKS - 1)) state_d = StPulse;
      end
      StPulse:   state_d = StRelease;
      StRelease: if (db_q == 2'b00) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign prompt_en  = (state_q == StPrompt) & phase_q;
  assign game_reset = (state_q == StPulse);
  assign dismissed  = (state_q == StPrompt) & press_q[1];
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_reset_prompt_ctrl.sv
// Directed bench for reset_prompt_ctrl with DEB=4, BLINK=3, TIMEOUT=10, tick every 4 clocks.
module tb_reset_prompt_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic game_over = 1'b0;
  logic btn_yes = 1'b0;
  logic btn_no = 1'b0;
  logic prompt_en, game_reset, dismissed, busy;

  int checks = 0;
  int errors = 0;
  int gr_cnt = 0;
  int dis_cnt = 0;
  int tick_div = 0;

  reset_prompt_ctrl #(
    .DEB_TICKS    (4),
    .BLINK_TICKS  (3),
    .TIMEOUT_TICKS(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .game_over (game_over),
    .btn_yes   (btn_yes),
    .btn_no    (btn_no),
    .prompt_en (prompt_en),
    .game_reset(game_reset),
    .dismissed (dismissed),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // tick changes 2 time units after a rising edge, one cycle high out of every four
  initial begin
    forever begin
      @(posedge clk);
      #2;
      tick_div = (tick_div + 1) % 4;
      tick = (tick_div == 0);
    end
  end

  always @(negedge clk) begin
    if (game_reset === 1'b1) gr_cnt++;
    if (dismissed === 1'b1) dis_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      step(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%0b after %0d cycles, required 0", name, busy, limit);
    end
  endtask

  task automatic enter_prompt(input string name);
    game_over = 1'b0;
    step(2);
    game_over = 1'b1;
    step(1);
    checks++;
    if (busy !== 1'b1 || prompt_en !== 1'b1) begin
      errors++;
      $display("FAIL %s: busy=%0b prompt_en=%0b, required 1/1", name, busy, prompt_en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    game_over = 1'b1;
    step(3);
    checks++;
    if (prompt_en !== 1'b0) begin
      errors++; $display("FAIL reset_prompt_en: got %0b required 0", prompt_en);
    end
    checks++;
    if (game_reset !== 1'b0) begin
      errors++; $display("FAIL reset_game_reset: got %0b required 0", game_reset);
    end
    checks++;
    if (dismissed !== 1'b0) begin
      errors++; $display("FAIL reset_dismissed: got %0b required 0", dismissed);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %0b required 0", busy);
    end
    rst = 1'b0;
    step(30);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL held_high_after_reset: busy=%0b required 0", busy);
    end
    game_over = 1'b0;
    step(2);
  endtask

  task automatic test_yes_press();
    int g0, d0, n;
    g0 = gr_cnt;
    d0 = dis_cnt;
    enter_prompt("yes_entry");
    n = 0;
    while (tick !== 1'b1 && n < 8) begin
      step(1);
      n++;
    end
    btn_yes = 1'b1;
    n = 0;
    while (n < 40) begin
      step(1);
      n++;
      if (game_reset === 1'b1) break;
    end
    // 2 sync edges, then samples on 4 ticks, then one FSM edge into PULSE
    checks++;
    if (n != 18 || game_reset !== 1'b1) begin
      errors++;
      $display("FAIL yes_latency: pulse seen at cycle %0d (game_reset=%0b), required 18", n,
               game_reset);
    end
    step(1);
    checks++;
    if (game_reset !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL yes_release_hold: game_reset=%0b busy=%0b, required 0/1", game_reset, busy);
    end
    step(6);
    btn_yes = 1'b0;
    step(4);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL yes_wait_debounce: busy=%0b required 1", busy);
    end
    wait_idle("yes_to_idle", 60);
    checks++;
    if (gr_cnt - g0 != 1 || dis_cnt != d0) begin
      errors++;
      $display("FAIL yes_pulse_count: resets=%0d dismisses=%0d, required 1/0", gr_cnt - g0,
               dis_cnt - d0);
    end
    step(60);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL yes_no_reprompt: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_glitch();
    int g0, k, c;
    logic exp_pe;
    g0 = gr_cnt;
    enter_prompt("glitch_entry");
    k = 0;
    c = 0;
    while (k < 9 && c < 80) begin
      exp_pe = ((k / 3) % 2) == 0;
      checks++;
      if (prompt_en !== exp_pe || game_reset !== 1'b0) begin
        errors++;
        $display("FAIL glitch_blink tick %0d: prompt_en=%0b game_reset=%0b, required %0b/0", k,
                 prompt_en, game_reset, exp_pe);
      end
      if (tick === 1'b1) begin
        k++;
        btn_yes = (k % 6 >= 1) && (k % 6 <= 3) && (k < 9);
      end
      step(1);
      c++;
    end
    btn_yes = 1'b0;
    checks++;
    if (k != 9 || gr_cnt != g0) begin
      errors++;
      $display("FAIL glitch_no_press: ticks=%0d resets=%0d, required 9/0", k, gr_cnt - g0);
    end
    wait_idle("glitch_timeout_idle", 60);
  endtask

  task automatic test_timeout();
    int g0, k;
    g0 = gr_cnt;
    enter_prompt("timeout_entry");
    k = 0;
    for (int c = 0; c < 80 && k < 10; c++) begin
      checks++;
      if (game_reset !== 1'b0) begin
        errors++; $display("FAIL timeout_early tick %0d: game_reset=%0b required 0", k, game_reset);
      end
      if (tick === 1'b1) k++;
      step(1);
    end
    checks++;
    if (game_reset !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse: game_reset=%0b after tick %0d, required 1", game_reset, k);
    end
    step(1);
    checks++;
    if (game_reset !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_release: game_reset=%0b busy=%0b, required 0/1", game_reset, busy);
    end
    step(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: busy=%0b required 0", busy);
    end
    step(40);
    checks++;
    if (gr_cnt - g0 != 1) begin
      errors++; $display("FAIL timeout_count: resets=%0d required 1", gr_cnt - g0);
    end
  endtask

  task automatic test_both();
    int g0, d0, n;
    g0 = gr_cnt;
    d0 = dis_cnt;
    enter_prompt("both_entry");
    btn_yes = 1'b1;
    btn_no = 1'b1;
    n = 0;
    while (dismissed !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    checks++;
    if (dismissed !== 1'b1) begin
      errors++; $display("FAIL both_dismissed: dismissed=%0b required 1", dismissed);
    end
    step(1);
    checks++;
    if (dismissed !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL both_one_cycle: dismissed=%0b busy=%0b, required 0/1", dismissed, busy);
    end
    step(8);
    btn_yes = 1'b0;
    btn_no = 1'b0;
    wait_idle("both_idle", 60);
    checks++;
    if (gr_cnt != g0 || dis_cnt - d0 != 1) begin
      errors++;
      $display("FAIL both_counts: resets=%0d dismisses=%0d, required 0/1", gr_cnt - g0,
               dis_cnt - d0);
    end
    step(60);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL both_no_reprompt: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_ignored();
    int g0, d0, seen;
    g0 = gr_cnt;
    d0 = dis_cnt;
    seen = 0;
    btn_yes = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (busy === 1'b1) seen++;
    end
    btn_yes = 1'b0;
    btn_no = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (busy === 1'b1) seen++;
    end
    btn_no = 1'b0;
    step(40);
    checks++;
    if (seen != 0 || gr_cnt != g0 || dis_cnt != d0) begin
      errors++;
      $display("FAIL idle_press_ignored: busy_cycles=%0d resets=%0d dismisses=%0d, required 0/0/0",
               seen, gr_cnt - g0, dis_cnt - d0);
    end
  endtask

  task automatic test_rst();
    int g0, k;
    g0 = gr_cnt;
    enter_prompt("rst_mid_entry");
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (prompt_en !== 1'b0 || game_reset !== 1'b0 || dismissed !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: pe=%0b gr=%0b dis=%0b busy=%0b, required 0/0/0/0",
               prompt_en, game_reset, dismissed, busy);
    end
    step(60);
    checks++;
    if (busy !== 1'b0 || gr_cnt != g0) begin
      errors++;
      $display("FAIL rst_mid_no_reprompt: busy=%0b resets=%0d, required 0/0", busy, gr_cnt - g0);
    end
    enter_prompt("rst_reprompt");
    // rst lands on the edge that would have taken the 10th tick into PULSE
    k = 0;
    for (int c = 0; c < 80; c++) begin
      if (tick === 1'b1) k++;
      if (k == 10) break;
      step(1);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (game_reset !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulse_outputs: gr=%0b busy=%0b, required 0/0", game_reset, busy);
    end
    step(60);
    checks++;
    if (gr_cnt != g0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulse_suppressed: resets=%0d busy=%0b, required 0/0", gr_cnt - g0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_yes_press();
    test_glitch();
    test_timeout();
    test_both();
    test_ignored();
    test_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_prompt_ctrl.md
RESET_PROMPT_CTRL -- requirements
Module: reset_prompt_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEB_TICKS      4    consecutive tick samples a button must differ from its debounced state before that state flips
  BLINK_TICKS    30   ticks per prompt blink half-period
  TIMEOUT_TICKS  600  ticks in PROMPT before auto-restart
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk        in   1  single system clock
  rst        in   1  reset, synchronous, active-high
  tick       in   1  one-cycle sampling strobe (frame/ms rate)
  game_over  in   1  level from game core; prompt requested while high
  btn_yes    in   1  raw asynchronous confirm button, active-high
  btn_no     in   1  raw asynchronous dismiss button, active-high
  prompt_en  out  1  drives en of the "RESET?" text renderer
  game_reset out  1  one-cycle game restart pulse
  dismissed  out  1  one-cycle pulse when the prompt is declined
  busy       out  1  high in any state other than IDLE

Function
REQ-003 Each button SHALL pass a 2-flop synchronizer before any other logic.
REQ-004 The debouncer SHALL sample the synchronized value only on tick.
  - A sample differing from the debounced state increments that button's counter.
  - A sample equal to the debounced state clears the counter.
  - When the counter reaches DEB_TICKS, the debounced state SHALL flip and the counter SHALL clear.
REQ-005 A press event SHALL be a debounced 0->1 transition, one cycle wide; releases SHALL generate no event.
REQ-006 The FSM SHALL have states IDLE, PROMPT, PULSE and RELEASE.
REQ-007 IDLE SHALL go to PROMPT on a rising edge of game_over (registered previous value); a level held high from reset or after dismissal SHALL NOT re-enter PROMPT.
REQ-008 On PROMPT entry, the blink counter and timeout counter SHALL clear and the blink phase SHALL be set to 1.
REQ-009 In PROMPT, the blink counter SHALL count ticks; at BLINK_TICKS-1 with tick, the counter SHALL wrap to 0 and the phase SHALL toggle.
REQ-010 prompt_en SHALL equal the blink phase in PROMPT and 0 in all other states.
REQ-011 PROMPT exits SHALL be evaluated in this priority order:
  - no press -> RELEASE with dismissed=1 for that cycle.
  - yes press -> PULSE.
  - timeout counter at TIMEOUT_TICKS-1 with tick -> PULSE.
REQ-012 When yes and no presses occur in the same cycle, no SHALL win.
REQ-013 A button press in any state other than PROMPT SHALL be ignored.
REQ-014 PULSE SHALL assert game_reset for exactly one cycle and then go to RELEASE.
REQ-015 RELEASE SHALL hold until both debounced buttons are 0 and SHALL then go to IDLE.
REQ-016 Outputs SHALL be registered or decoded from registered state only, with no combinational path from the buttons.
REQ-017 Counters SHALL be sized with $clog2 of their parameter and SHALL NOT overflow.

Reset
REQ-018 A synchronous rst SHALL force, regardless of current state:
  - FSM to IDLE.
  - All counters, blink phase, debounced states, synchronizers and the game_over edge register to 0.
  - prompt_en=0, game_reset=0, dismissed=0, busy=0.
REQ-019 rst asserted during PROMPT or PULSE SHALL suppress any pending game_reset or dismissed pulse.

Verification (DEB_TICKS=4, BLINK_TICKS=3, TIMEOUT_TICKS=10, tick every 4 clk)
REQ-020 Drive game_over 0->1, then btn_yes high for 6 ticks -> one game_reset pulse 4 ticks (+2-flop latency) after press; then RELEASE until btn_yes is debounced low; then IDLE, busy=0.
REQ-021 In PROMPT, drive 3-tick btn_yes glitches -> no press event and no game_reset; prompt_en toggles every 3 ticks starting at 1.
REQ-022 In PROMPT, hold no buttons -> game_reset at the 10th tick; zero extra pulses.
REQ-023 Drive btn_yes and btn_no rising together and held -> dismissed=1 for one cycle, game_reset stays 0; with game_over held high, FSM returns to IDLE and does not re-prompt.
REQ-024 Assert rst mid-PROMPT -> next cycle all outputs 0 and state IDLE; game_over must toggle low->high to re-prompt.
